// File: rtl/top_k_rx_deserializer_pkg.sv
// Shared constants and types for the top-k receive deserializer.
package top_k_pkg;

    localparam int INTEGER_SIZE = 32;
    localparam int LANES        = 16;
    localparam int KEEP_W       = LANES * (INTEGER_SIZE / 8);
    localparam int LANE_IDX_W   = 4;
    localparam int NLANES_W     = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/top_k_rx_deserializer_if.sv
// Stream bundle for the deserializer: 512-bit receive side in, 32-bit integer side out.
// The slave modport is the deserializer's view; master is the surrounding environment.
interface top_k_rx_deserializer_if #(
    parameter int DATA_WIDTH   = 512,
    parameter int INTEGER_SIZE = 32
);

    logic [DATA_WIDTH-1:0]   s_axis_rx_TDATA;
    logic [DATA_WIDTH/8-1:0] s_axis_rx_TKEEP;
    logic                    s_axis_rx_TVALID;
    logic                    s_axis_rx_TLAST;
    logic                    s_axis_rx_TREADY;

    logic [INTEGER_SIZE-1:0] m_axis_int_TDATA;
    logic                    m_axis_int_TVALID;
    logic                    m_axis_int_TLAST;
    logic                    m_axis_int_TREADY;
    logic                    m_axis_int_clear;

    modport slave (
        input  s_axis_rx_TDATA, s_axis_rx_TKEEP, s_axis_rx_TVALID, s_axis_rx_TLAST,
        output s_axis_rx_TREADY,
        output m_axis_int_TDATA, m_axis_int_TVALID, m_axis_int_TLAST, m_axis_int_clear,
        input  m_axis_int_TREADY
    );

    modport master (
        output s_axis_rx_TDATA, s_axis_rx_TKEEP, s_axis_rx_TVALID, s_axis_rx_TLAST,
        input  s_axis_rx_TREADY,
        input  m_axis_int_TDATA, m_axis_int_TVALID, m_axis_int_TLAST, m_axis_int_clear,
        output m_axis_int_TREADY
    );

endinterface

// File: rtl/top_k_rx_deserializer_keep_decode.sv
// TKEEP decode: length of the contiguous all-ones lane prefix and a malformed flag.
module top_k_keep_decode
    import top_k_pkg::*;
(
    input  logic [KEEP_W-1:0]   i_keep,
    output logic [NLANES_W-1:0] o_n_lanes,
    output logic                o_malformed
);

    logic w_in_prefix;

    // Walk lanes from 0 upward; a full lane after a gap or any partial nibble is malformed
    always_comb begin
        o_n_lanes   = '0;
        o_malformed = 1'b0;
        w_in_prefix = 1'b1;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i_keep[4*i +: 4] == 4'hF) begin
                if (w_in_prefix) begin
                    o_n_lanes = o_n_lanes + NLANES_W'(1);
                end else begin
                    o_malformed = 1'b1;
                end
            end else begin
                w_in_prefix = 1'b0;
                if (i_keep[4*i +: 4] != 4'h0) begin
                    o_malformed = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/top_k_rx_deserializer.sv
// Splits each accepted 512-bit receive word into 32-bit integers, one per cycle,
// tagging the first integer of every frame with clear and the last with TLAST.
module top_k_rx_deserializer
    import top_k_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int INTEGER_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    top_k_rx_deserializer_if.slave bus,
    output logic [31:0]            frame_count,
    output logic [15:0]            err_count
);

    localparam int NUM_LANES = DATA_WIDTH / INTEGER_SIZE;

    state_t                                  r_state;
    logic [NUM_LANES-1:0][INTEGER_SIZE-1:0]  r_word;
    logic [NLANES_W-1:0]                     r_nlanes;
    logic                                    r_last;
    logic [LANE_IDX_W-1:0]                   r_idx;
    logic                                    r_clear_pend;
    logic                                    r_tvalid;
    logic                                    r_tlast;
    logic                                    r_clear;
    logic [INTEGER_SIZE-1:0]                 r_tdata;
    logic [31:0]                             r_frame_count;
    logic [15:0]                             r_err_count;

    logic [NUM_LANES-1:0][INTEGER_SIZE-1:0]  w_in_word;
    logic [NLANES_W-1:0]                     w_n_lanes;
    logic [NLANES_W-1:0]                     w_eff_lanes;
    logic [LANE_IDX_W-1:0]                   w_idx_nxt;
    logic                                    w_malformed;
    logic                                    w_m_hs;
    logic                                    w_final_lane;
    logic                                    w_next_final;
    logic                                    w_accept;
    logic                                    w_empty;
    logic                                    w_keep_word;
    logic                                    w_clear_next;

    top_k_keep_decode u_keep_decode (
        .i_keep      (bus.s_axis_rx_TKEEP),
        .o_n_lanes   (w_n_lanes),
        .o_malformed (w_malformed)
    );

    assign w_in_word    = bus.s_axis_rx_TDATA;
    assign w_m_hs       = r_tvalid && bus.m_axis_int_TREADY;
    assign w_final_lane = ({1'b0, r_idx} == (r_nlanes - NLANES_W'(1)));
    assign w_idx_nxt    = r_idx + LANE_IDX_W'(1);
    assign w_next_final = ({1'b0, w_idx_nxt} == (r_nlanes - NLANES_W'(1)));

    // Ready while idle or on the handshake that retires the final lane of the held word
    assign bus.s_axis_rx_TREADY = !rst && ((r_state == ST_IDLE) || (w_m_hs && w_final_lane));

    assign w_accept     = bus.s_axis_rx_TVALID && bus.s_axis_rx_TREADY;
    assign w_empty      = (w_n_lanes == '0);
    // An empty word still carrying TLAST becomes a single zero integer so the frame end survives
    assign w_keep_word  = !w_empty || bus.s_axis_rx_TLAST;
    assign w_eff_lanes  = w_empty ? NLANES_W'(1) : w_n_lanes;
    // Clear state as it will be after any handshake happening this cycle
    assign w_clear_next = w_m_hs ? r_tlast : r_clear_pend;

    // Word hold FSM with registered integer outputs, frame and error counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_word        <= '0;
            r_nlanes      <= '0;
            r_last        <= 1'b0;
            r_idx         <= '0;
            r_clear_pend  <= 1'b1;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_clear       <= 1'b0;
            r_tdata       <= '0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            if (w_m_hs) begin
                r_clear_pend <= r_tlast;
            end
            if (w_m_hs && r_tlast) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (w_accept && (w_malformed || (w_empty && bus.s_axis_rx_TLAST))
                && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 16'd1;
            end

            if (w_accept && w_keep_word) begin
                r_state  <= ST_DRAIN;
                r_word   <= w_empty ? '0 : w_in_word;
                r_nlanes <= w_eff_lanes;
                r_last   <= bus.s_axis_rx_TLAST;
                r_idx    <= '0;
                r_tvalid <= 1'b1;
                r_tdata  <= w_empty ? '0 : w_in_word[0];
                r_tlast  <= bus.s_axis_rx_TLAST && (w_eff_lanes == NLANES_W'(1));
                r_clear  <= w_clear_next;
            end else if (w_accept || (w_m_hs && w_final_lane)) begin
                // Either a dropped empty word or the last lane left with nothing queued behind it
                r_state  <= ST_IDLE;
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
                r_tlast  <= 1'b0;
                r_clear  <= 1'b0;
            end else if (w_m_hs) begin
                r_idx    <= w_idx_nxt;
                r_tdata  <= r_word[w_idx_nxt];
                r_tlast  <= r_last && w_next_final;
                r_clear  <= 1'b0;
            end
        end
    end

    assign bus.m_axis_int_TDATA  = r_tdata;
    assign bus.m_axis_int_TVALID = r_tvalid;
    assign bus.m_axis_int_TLAST  = r_tlast;
    assign bus.m_axis_int_clear  = r_clear;
    assign frame_count           = r_frame_count;
    assign err_count             = r_err_count;

endmodule
